// File: rtl/tlb_pkg.sv
// Shared types and constants for the LA32R TLB.
//   tlb_page_t  : per-page payload {ppn, plv, mat, d, v} (26 bits)
//   tlb_entry_t : full entry {e, asid, g, ps, vppn, p0, p1} (89 bits)
//   inv_state_e : INVTLB sweep controller states
package tlb_pkg;

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_page_t;

    typedef struct packed {
        logic        e;
        logic [9:0]  asid;
        logic        g;
        logic [5:0]  ps;
        logic [18:0] vppn;
        tlb_page_t   p0;
        tlb_page_t   p1;
    } tlb_entry_t;

    localparam logic [5:0] PS_4K = 6'd12;
    localparam logic [5:0] PS_2M = 6'd21;

    localparam logic [4:0] INV_ALL0          = 5'd0;
    localparam logic [4:0] INV_ALL1          = 5'd1;
    localparam logic [4:0] INV_GLOBAL        = 5'd2;
    localparam logic [4:0] INV_NONGLOBAL     = 5'd3;
    localparam logic [4:0] INV_ASID          = 5'd4;
    localparam logic [4:0] INV_ASID_VA       = 5'd5;
    localparam logic [4:0] INV_GLOBAL_ASID_VA = 5'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } inv_state_e;

endpackage

// File: rtl/tlb_entry_match.sv
// Combinational match of one TLB entry against a VPPN/ASID probe.
//   entry_i       : entry under test (e bit already reflects live state)
//   vppn_i        : probe va[31:13]
//   va12_i        : probe va[12], odd-page select for 4 KiB pages
//   asid_i        : probe ASID
//   ignore_asid_i : treat the ASID check as satisfied (VA-only compare)
//   match_o       : E & (G | ignore | ASID equal) & page-size-masked VPPN equal
//   odd_o         : selects page 1 when set
module tlb_entry_match
    import tlb_pkg::*;
(
    input  tlb_entry_t  entry_i,
    input  logic [18:0] vppn_i,
    input  logic        va12_i,
    input  logic [9:0]  asid_i,
    input  logic        ignore_asid_i,
    output logic        match_o,
    output logic        odd_o
);

    logic is_2m;
    logic vppn_hit;
    logic asid_hit;

    assign is_2m    = (entry_i.ps == PS_2M);
    // A 2 MiB page pair spans 4 MiB, so only vppn[18:9] identifies it.
    assign vppn_hit = is_2m ? (entry_i.vppn[18:9] == vppn_i[18:9])
                            : (entry_i.vppn == vppn_i);
    assign asid_hit = entry_i.g | ignore_asid_i | (entry_i.asid == asid_i);
    assign match_o  = entry_i.e & asid_hit & vppn_hit;
    // For 2 MiB pages the odd/even bit is va[21], i.e. vppn[8].
    assign odd_o    = is_2m ? vppn_i[8] : va12_i;

endmodule

// File: rtl/tlb_lookup_unit.sv
// Fully-associative LA32R TLB.
//   Lookup : s_valid/s_vppn/s_va12/s_asid -> r_* one cycle later (lowest index wins)
//   Write  : w_en/w_index/w_entry, applied at the clock edge
//   Read   : rd_index -> rd_entry, registered
//   INVTLB : inv_valid/inv_op/inv_asid/inv_vppn start a one-entry-per-cycle
//            sweep; s_ready drops while busy, inv_done pulses at the end
module tlb_lookup_unit
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 16,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [18:0]     s_vppn,
    input  logic            s_va12,
    input  logic [9:0]      s_asid,
    output logic            r_valid,
    output logic            r_found,
    output logic [IDXW-1:0] r_index,
    output logic [19:0]     r_ppn,
    output logic [5:0]      r_ps,
    output logic [1:0]      r_plv,
    output logic [1:0]      r_mat,
    output logic            r_d,
    output logic            r_v,
    input  logic            w_en,
    input  logic [IDXW-1:0] w_index,
    input  tlb_entry_t      w_entry,
    input  logic [IDXW-1:0] rd_index,
    output tlb_entry_t      rd_entry,
    input  logic            inv_valid,
    input  logic [4:0]      inv_op,
    input  logic [9:0]      inv_asid,
    input  logic [18:0]     inv_vppn,
    output logic            inv_done
);

    // Entry payload has no reset; only the E bits are reset and swept.
    tlb_entry_t        ent_q [TLBNUM];
    logic [TLBNUM-1:0] e_q;
    tlb_entry_t        view  [TLBNUM];

    inv_state_e        state_q;
    logic [IDXW-1:0]   cnt_q;
    logic              inv_done_q;
    logic [4:0]        inv_op_q;
    logic [9:0]        inv_asid_q;
    logic [18:0]       inv_vppn_q;

    logic              accept;
    logic [TLBNUM-1:0] lk_match;
    logic [TLBNUM-1:0] lk_odd;

    logic              r_valid_q, r_found_q, r_found_d;
    logic [IDXW-1:0]   r_index_q, r_index_d;
    logic [5:0]        r_ps_q, r_ps_d;
    tlb_page_t         r_pg_q, r_pg_d;
    tlb_entry_t        rd_entry_q;

    tlb_entry_t        sel_ent;
    tlb_entry_t        sw_ent;
    logic              sw_va_hit, sw_odd_unused, sw_pred, sweep_clr, asid_eq;

    always_comb begin
        for (int i = 0; i < TLBNUM; i++) begin
            view[i]   = ent_q[i];
            view[i].e = e_q[i];
        end
    end

    assign s_ready = resetn & (state_q == ST_IDLE);
    assign accept  = s_valid & s_ready;

    for (genvar g = 0; g < TLBNUM; g++) begin : g_lk
        tlb_entry_match u_match (
            .entry_i       (view[g]),
            .vppn_i        (s_vppn),
            .va12_i        (s_va12),
            .asid_i        (s_asid),
            .ignore_asid_i (1'b0),
            .match_o       (lk_match[g]),
            .odd_o         (lk_odd[g])
        );
    end

    // Priority encoder: scan downward so the lowest matching index is kept.
    always_comb begin
        r_found_d = 1'b0;
        r_index_d = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (lk_match[i]) begin
                r_found_d = 1'b1;
                r_index_d = IDXW'(i);
            end
        end
        sel_ent = view[r_index_d];
        r_pg_d  = '0;
        r_ps_d  = '0;
        if (r_found_d) begin
            r_pg_d = lk_odd[r_index_d] ? sel_ent.p1 : sel_ent.p0;
            r_ps_d = sel_ent.ps;
        end
    end

    // Sweep predicate on the entry addressed by the counter; the match
    // instance ignores ASID so it yields a pure E & VA compare.
    assign sw_ent  = view[cnt_q];
    assign asid_eq = (sw_ent.asid == inv_asid_q);

    tlb_entry_match u_sweep_match (
        .entry_i       (sw_ent),
        .vppn_i        (inv_vppn_q),
        .va12_i        (1'b0),
        .asid_i        (inv_asid_q),
        .ignore_asid_i (1'b1),
        .match_o       (sw_va_hit),
        .odd_o         (sw_odd_unused)
    );

    always_comb begin
        case (inv_op_q)
            INV_ALL0, INV_ALL1: sw_pred = 1'b1;
            INV_GLOBAL:         sw_pred = sw_ent.g;
            INV_NONGLOBAL:      sw_pred = ~sw_ent.g;
            INV_ASID:           sw_pred = ~sw_ent.g & asid_eq;
            INV_ASID_VA:        sw_pred = ~sw_ent.g & asid_eq & sw_va_hit;
            INV_GLOBAL_ASID_VA: sw_pred = (sw_ent.g | asid_eq) & sw_va_hit;
            default:            sw_pred = 1'b0;
        endcase
    end

    assign sweep_clr = (state_q == ST_SWEEP) & sw_pred;

    always_ff @(posedge clk) begin
        if (w_en) begin
            ent_q[w_index] <= w_entry;
        end
    end

    // A write to the entry being swept lands after the clear, so it wins.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            e_q <= '0;
        end else begin
            if (sweep_clr) begin
                e_q[cnt_q] <= 1'b0;
            end
            if (w_en) begin
                e_q[w_index] <= w_entry.e;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && inv_valid) begin
            inv_op_q   <= inv_op;
            inv_asid_q <= inv_asid;
            inv_vppn_q <= inv_vppn;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            inv_done_q <= 1'b0;
        end else begin
            inv_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (inv_valid) begin
                        state_q <= ST_SWEEP;
                        cnt_q   <= '0;
                    end
                end
                ST_SWEEP: begin
                    cnt_q <= cnt_q + IDXW'(1);
                    if (cnt_q == IDXW'(TLBNUM - 1)) begin
                        state_q    <= ST_DONE;
                        inv_done_q <= 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid_q  <= 1'b0;
            r_found_q  <= 1'b0;
            r_index_q  <= '0;
            r_ps_q     <= '0;
            r_pg_q     <= '0;
            rd_entry_q <= '0;
        end else begin
            r_valid_q  <= accept;
            rd_entry_q <= view[rd_index];
            if (accept) begin
                r_found_q <= r_found_d;
                r_index_q <= r_index_d;
                r_ps_q    <= r_ps_d;
                r_pg_q    <= r_pg_d;
            end
        end
    end

    assign r_valid  = r_valid_q;
    assign r_found  = r_found_q;
    assign r_index  = r_index_q;
    assign r_ppn    = r_pg_q.ppn;
    assign r_ps     = r_ps_q;
    assign r_plv    = r_pg_q.plv;
    assign r_mat    = r_pg_q.mat;
    assign r_d      = r_pg_q.d;
    assign r_v      = r_pg_q.v;
    assign rd_entry = rd_entry_q;
    assign inv_done = inv_done_q;

endmodule

// File: tb/tb_tlb_lookup_unit.sv
module tb_tlb_lookup_unit;
    import tlb_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [18:0] s_vppn = '0;
    logic        s_va12 = 1'b0;
    logic [9:0]  s_asid = '0;
    logic        r_valid, r_found, r_d, r_v;
    logic [3:0]  r_index;
    logic [19:0] r_ppn;
    logic [5:0]  r_ps;
    logic [1:0]  r_plv, r_mat;
    logic        w_en = 1'b0;
    logic [3:0]  w_index = '0;
    tlb_entry_t  w_entry = '0;
    logic [3:0]  rd_index = '0;
    tlb_entry_t  rd_entry;
    logic        inv_valid = 1'b0;
    logic [4:0]  inv_op = '0;
    logic [9:0]  inv_asid = '0;
    logic [18:0] inv_vppn = '0;
    logic        inv_done;

    int tests = 0;
    int failed = 0;

    tlb_entry_t m [16];

    always #5 clk = ~clk;

    tlb_lookup_unit #(.TLBNUM(16), .IDXW(4)) dut (
        .clk(clk), .resetn(resetn),
        .s_valid(s_valid), .s_ready(s_ready), .s_vppn(s_vppn), .s_va12(s_va12), .s_asid(s_asid),
        .r_valid(r_valid), .r_found(r_found), .r_index(r_index), .r_ppn(r_ppn), .r_ps(r_ps),
        .r_plv(r_plv), .r_mat(r_mat), .r_d(r_d), .r_v(r_v),
        .w_en(w_en), .w_index(w_index), .w_entry(w_entry),
        .rd_index(rd_index), .rd_entry(rd_entry),
        .inv_valid(inv_valid), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
        .inv_done(inv_done)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit va_eq(input tlb_entry_t t, input logic [18:0] v);
        if (t.ps == 6'd21) return t.vppn[18:9] == v[18:9];
        return t.vppn == v;
    endfunction

    function automatic bit inv_hits(input tlb_entry_t t, input logic [4:0] op,
                                    input logic [9:0] asid, input logic [18:0] v);
        bit a;
        a = (t.asid == asid);
        case (op)
            5'd0, 5'd1: return 1'b1;
            5'd2:       return t.g;
            5'd3:       return !t.g;
            5'd4:       return !t.g && a;
            5'd5:       return !t.g && a && va_eq(t, v);
            5'd6:       return (t.g || a) && va_eq(t, v);
            default:    return 1'b0;
        endcase
    endfunction

    function automatic void model_lookup(input logic [18:0] v, input logic va12, input logic [9:0] asid,
                                         output logic found, output logic [3:0] idx,
                                         output tlb_page_t pg, output logic [5:0] ps);
        logic odd;
        found = 1'b0; idx = '0; pg = '0; ps = '0;
        for (int i = 0; i < 16; i++) begin
            if (!found && m[i].e && (m[i].g || m[i].asid == asid) && va_eq(m[i], v)) begin
                found = 1'b1;
                idx   = 4'(i);
                ps    = m[i].ps;
                odd   = (m[i].ps == 6'd21) ? v[8] : va12;
                pg    = odd ? m[i].p1 : m[i].p0;
            end
        end
    endfunction

    function automatic logic [18:0] rand_vppn();
        return 19'((($urandom % 4) << 9) | (($urandom % 2) << 8) | ($urandom % 4));
    endfunction

    function automatic tlb_entry_t rand_ent();
        tlb_entry_t t;
        t      = '0;
        t.e    = ($urandom % 4) != 0;
        t.asid = 10'($urandom % 3);
        t.g    = ($urandom % 4) == 0;
        t.ps   = ($urandom % 2) ? 6'd21 : 6'd12;
        t.vppn = rand_vppn();
        t.p0   = 26'($urandom);
        t.p1   = 26'($urandom);
        return t;
    endfunction

    task automatic check_result(input string tag, input logic f, input logic [3:0] ix,
                                input tlb_page_t pg, input logic [5:0] ps);
        chk({tag, ".valid"}, r_valid, 1);
        chk({tag, ".found"}, r_found, f);
        chk({tag, ".index"}, r_index, ix);
        chk({tag, ".ppn"},   r_ppn, pg.ppn);
        chk({tag, ".ps"},    r_ps, ps);
        chk({tag, ".plv"},   r_plv, pg.plv);
        chk({tag, ".mat"},   r_mat, pg.mat);
        chk({tag, ".d"},     r_d, pg.d);
        chk({tag, ".v"},     r_v, pg.v);
    endtask

    task automatic do_lookup(input string tag, input logic [18:0] v, input logic va12, input logic [9:0] asid);
        logic f; logic [3:0] ix; tlb_page_t pg; logic [5:0] ps;
        model_lookup(v, va12, asid, f, ix, pg, ps);
        s_valid = 1'b1; s_vppn = v; s_va12 = va12; s_asid = asid;
        @(posedge clk); #1;
        s_valid = 1'b0;
        check_result(tag, f, ix, pg, ps);
    endtask

    task automatic do_write(input logic [3:0] idx, input tlb_entry_t t);
        w_en = 1'b1; w_index = idx; w_entry = t;
        @(posedge clk); #1;
        w_en = 1'b0;
        m[idx] = t;
    endtask

    task automatic do_rd(input string tag, input logic [3:0] idx);
        rd_index = idx;
        @(posedge clk); #1;
        chk(tag, rd_entry, m[idx]);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("reset.ready", s_ready, 0);
        chk("reset.rvalid", r_valid, 0);
        chk("reset.done", inv_done, 0);
        chk("reset.found", r_found, 0);
        chk("reset.rd", rd_entry, 0);
        resetn = 1'b1;
        #1;
        chk("reset.ready_after", s_ready, 1);
        for (int i = 0; i < 16; i++) m[i].e = 1'b0;
    endtask

    task automatic do_sweep(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] v,
                            input int wr_at, input tlb_entry_t wr_ent);
        inv_valid = 1'b1; inv_op = op; inv_asid = asid; inv_vppn = v;
        for (int i = 0; i < 16; i++) if (inv_hits(m[i], op, asid, v)) m[i].e = 1'b0;
        @(posedge clk); #1;
        // Lookups and new INVTLB requests are offered throughout and must be ignored.
        s_valid = 1'b1; s_vppn = v; s_asid = asid;
        for (int k = 1; k <= 17; k++) begin
            chk("sweep.ready", s_ready, 0);
            chk("sweep.rvalid", r_valid, 0);
            chk("sweep.done", inv_done, (k == 17));
            if (k - 1 == wr_at) begin
                w_en = 1'b1; w_index = wr_at[3:0]; w_entry = wr_ent;
            end
            @(posedge clk); #1;
            w_en = 1'b0;
            if (k - 1 == wr_at) m[wr_at] = wr_ent;
        end
        inv_valid = 1'b0; s_valid = 1'b0;
        chk("sweep.ready_end", s_ready, 1);
        chk("sweep.done_end", inv_done, 0);
        chk("sweep.rvalid_end", r_valid, 0);
    endtask

    initial begin
        tlb_entry_t t;
        logic f; logic [3:0] ix; tlb_page_t pg; logic [5:0] ps;
        for (int i = 0; i < 16; i++) m[i] = '0;

        do_reset();
        for (int i = 0; i < 16; i++) do_write(4'(i), '0);

        // Empty TLB miss
        do_lookup("miss0", 19'h12345, 1'b0, 10'd0);
        chk("miss0.ppn_const", r_ppn, 0);

        // 4 KiB entry, odd page
        t = '0; t.e = 1; t.g = 0; t.asid = 10'd5; t.ps = 6'd12; t.vppn = 19'h12345;
        t.p1.ppn = 20'hABCDE; t.p1.mat = 2'd1; t.p1.v = 1;
        do_write(4'd3, t);
        do_lookup("hit4k", 19'h12345, 1'b1, 10'd5);
        chk("hit4k.index_const", r_index, 3);
        chk("hit4k.ppn_const", r_ppn, 20'hABCDE);
        do_lookup("asidmiss", 19'h12345, 1'b1, 10'd6);
        chk("asidmiss.found_const", r_found, 0);

        // 2 MiB entry, vppn[8]=0 selects page 0
        t = '0; t.e = 1; t.g = 1; t.asid = 10'd9; t.ps = 6'd21; t.vppn = 19'h12200;
        t.p0.ppn = 20'h11111; t.p0.plv = 2'd3; t.p0.d = 1; t.p1.ppn = 20'h22222;
        do_write(4'd7, t);
        do_lookup("hit2m", 19'h122FF, 1'b1, 10'd1);
        chk("hit2m.ps_const", r_ps, 21);
        chk("hit2m.ppn_const", r_ppn, 20'h11111);

        // Two matches: lowest index wins
        t = '0; t.e = 1; t.asid = 10'd1; t.ps = 6'd12; t.vppn = 19'h00ABC; t.p0.ppn = 20'h00002;
        do_write(4'd2, t);
        t.p0.ppn = 20'h00009;
        do_write(4'd9, t);
        do_lookup("multi", 19'h00ABC, 1'b0, 10'd1);
        chk("multi.index_const", r_index, 2);
        do_rd("rd9", 4'd9);

        // Same-cycle write and lookup/read see the old contents
        model_lookup(19'h00ABC, 1'b0, 10'd1, f, ix, pg, ps);
        t.p0.ppn = 20'h00000;
        w_en = 1; w_index = 4'd0; w_entry = t; s_valid = 1; s_vppn = 19'h00ABC; s_va12 = 0; s_asid = 10'd1;
        rd_index = 4'd0;
        @(posedge clk); #1;
        chk("wrsame.rd_old", rd_entry, m[0]);
        w_en = 0; s_valid = 0;
        check_result("wrsame", f, ix, pg, ps);
        m[0] = t;
        do_lookup("wrafter", 19'h00ABC, 1'b0, 10'd1);
        chk("wrafter.index_const", r_index, 0);

        // Randomized mix of writes, lookups and reads
        for (int n = 0; n < 150; n++) begin
            case ($urandom % 3)
                0: do_write(4'($urandom % 16), rand_ent());
                1: do_lookup("rnd", rand_vppn(), 1'($urandom % 2), 10'($urandom % 3));
                default: do_rd("rnd.rd", 4'($urandom % 16));
            endcase
        end

        // INVTLB op 4, ASID 5
        do_reset();
        t = '0; t.e = 1; t.g = 0; t.asid = 10'd5; t.ps = 6'd12; t.vppn = 19'h00100; t.p0.ppn = 20'h1;
        do_write(4'd1, t);
        t.vppn = 19'h00300; t.p0.ppn = 20'h3;
        do_write(4'd3, t);
        t.asid = 10'd6; t.vppn = 19'h00400; t.p0.ppn = 20'h4;
        do_write(4'd4, t);
        do_sweep(5'd4, 10'd5, 19'h0, -1, '0);
        do_lookup("inv4.idx1", 19'h00100, 1'b0, 10'd5);
        chk("inv4.idx1_const", r_found, 0);
        do_lookup("inv4.idx3", 19'h00300, 1'b0, 10'd5);
        do_lookup("inv4.idx4", 19'h00400, 1'b0, 10'd6);
        chk("inv4.idx4_const", r_found, 1);

        // Randomized sweeps with every op including illegal ones
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 16; i++) do_write(4'(i), rand_ent());
            do_sweep(5'($urandom % 8), 10'($urandom % 3), rand_vppn(), -1, '0);
            for (int i = 0; i < 16; i++) do_rd("rsweep.rd", 4'(i));
            for (int i = 0; i < 6; i++) do_lookup("rsweep", rand_vppn(), 1'($urandom % 2), 10'($urandom % 3));
        end

        // Write to the entry being swept wins over the clear
        t = '0; t.e = 1; t.g = 1; t.ps = 6'd12; t.vppn = 19'h00555; t.p0.ppn = 20'h55555;
        do_sweep(5'd0, 10'd0, 19'h0, 5, t);
        do_rd("sweepwr.rd5", 4'd5);
        do_lookup("sweepwr", 19'h00555, 1'b0, 10'd2);
        chk("sweepwr.found_const", r_found, 1);
        do_rd("sweepwr.rd6", 4'd6);

        // Reset in the middle of a sweep
        for (int i = 0; i < 16; i++) do_write(4'(i), rand_ent());
        inv_valid = 1; inv_op = 5'd7;
        @(posedge clk); #1;
        inv_valid = 0;
        for (int k = 1; k <= 5; k++) begin
            chk("midrst.ready", s_ready, 0);
            chk("midrst.done", inv_done, 0);
            if (k == 5) resetn = 0;
            @(posedge clk); #1;
        end
        chk("midrst.ready_rst", s_ready, 0);
        resetn = 1; #1;
        chk("midrst.ready_idle", s_ready, 1);
        for (int i = 0; i < 16; i++) m[i].e = 1'b0;
        for (int k = 0; k < 20; k++) begin
            chk("midrst.nodone", inv_done, 0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 6; i++) begin
            do_lookup("midrst.lk", rand_vppn(), 1'($urandom % 2), 10'($urandom % 3));
            chk("midrst.miss_const", r_found, 0);
        end
        do_rd("midrst.rd", 4'($urandom % 16));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
